micro_ondas_pwr: RTL and testbench

Parametrised microwave controller, the next generation of the single-power `micro_ondas` top level. It adds configurable display digit count and seconds prescaler, ten selectable power levels realised as magnetron duty cycling, pause/resume, and a one-cycle completion pulse. It takes debounced, synchronous front-panel inputs and drives the magnetron enable and packed 7-segment outputs.

---
 rtl/micro_ondas_pkg.sv | 27 ++
 rtl/micro_ondas_pwr_seg7.sv | 16 +
 rtl/micro_ondas_pwr.sv | 247 ++++++++++++++++++++++++
 tb/tb_micro_ondas_pwr.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_ondas_pkg.sv
// Shared types and constants for the micro_ondas_pwr microwave controller.
// Contents: controller state enum, 7-segment table for BCD 0-9,
// default/maximum power, duty-phase wrap value, quick-start seconds tens.
package micro_ondas_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned KEY_N = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PWRSEL = 2'd1,
        ST_RUN    = 2'd2,
        ST_PAUSE  = 2'd3
    } state_e;

    // Active-high segments, bit order gfedcba.
    localparam logic [SEG_W-1:0] SEG7 [KEY_N] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [BCD_W-1:0] DEFAULT_POWER   = 4'd10;
    localparam logic [BCD_W-1:0] PHASE_MAX       = 4'd9;
    localparam logic [BCD_W-1:0] QUICK_SECS_TENS = 4'd3;

endpackage

// File: rtl/micro_ondas_pwr_seg7.sv
// BCD to 7-segment decoder (module seg7_dec), purely combinational.
// Ports: bcd   - 4-bit BCD digit in
//        seg_c - 7-bit segments out (gfedcba, active high); codes >= 10 blank.
module seg7_dec
    import micro_ondas_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = '0;
        if (bcd < 4'd10) seg_c = SEG7[bcd];
    end

endmodule

// File: rtl/micro_ondas_pwr.sv
// Microwave controller: keypad time entry, ten power levels via magnetron
// duty cycling, pause/resume and a one-cycle completion pulse.
// Optional feature macro: MICRO_ONDAS_QUICK_START_EN (start at 0:00 loads
// 0:30, start while running adds 30 s).
// Ports: clock, clearn (sync active-low reset / clear button),
//        keypad[9:0] one-hot digit keys, power_key, startn, stopn,
//        door_closed; segs[7*DIGITS-1:0] display, mag_on, running,
//        paused, done (one-cycle completion pulse).
module micro_ondas_pwr
    import micro_ondas_pkg::*;
#(
    parameter int unsigned CLK_DIV = 100,
    parameter int unsigned DIGITS  = 4
) (
    input  logic                      clock,
    input  logic                      clearn,
    input  logic [KEY_N-1:0]          keypad,
    input  logic                      power_key,
    input  logic                      startn,
    input  logic                      stopn,
    input  logic                      door_closed,
    output logic [SEG_W*DIGITS-1:0]   segs,
    output logic                      mag_on,
    output logic                      running,
    output logic                      paused,
    output logic                      done
);

    localparam int unsigned PRE_W = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    state_e                         state_q, state_d;
    logic [DIGITS-1:0][BCD_W-1:0]   time_q, time_d, time_dec;
    logic [BCD_W-1:0]               power_q, power_d;
    logic [BCD_W-1:0]               phase_q, phase_d;
    logic [PRE_W-1:0]               presc_q, presc_d;
    logic [KEY_N-1:0]               key_prev_q, key_prev_d;
    logic                           pwr_prev_q, pwr_prev_d;
    logic                           start_prev_q, start_prev_d;
    logic                           stop_prev_q, stop_prev_d;
    logic                           done_q, done_d;

    logic                           key_press, pwr_press, start_press, stop_press;
    logic [BCD_W-1:0]               key_val;
    logic                           tick, time_zero, borrow;

    // State and datapath registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (!clearn) begin
            state_q      <= ST_IDLE;
            time_q       <= '0;
            power_q      <= DEFAULT_POWER;
            phase_q      <= '0;
            presc_q      <= '0;
            key_prev_q   <= '0;
            pwr_prev_q   <= 1'b0;
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            time_q       <= time_d;
            power_q      <= power_d;
            phase_q      <= phase_d;
            presc_q      <= presc_d;
            key_prev_q   <= key_prev_d;
            pwr_prev_q   <= pwr_prev_d;
            start_prev_q <= start_prev_d;
            stop_prev_q  <= stop_prev_d;
            done_q       <= done_d;
        end
    end

    // Press edge detection; a non-one-hot keypad word never yields a press.
    always_comb begin
        key_val = '0;
        for (int k = 0; k < KEY_N; k++) begin
            if (keypad[k]) key_val = BCD_W'(k);
        end
        key_press   = $onehot(keypad) && ((keypad & ~key_prev_q) != '0);
        pwr_press   = power_key & ~pwr_prev_q;
        start_press = ~startn & ~start_prev_q;
        stop_press  = ~stopn & ~stop_prev_q;
    end

    // One-second decrement with decimal borrow through the minute digits.
    always_comb begin
        time_dec = time_q;
        borrow   = 1'b0;
        if (time_q[0] != '0) begin
            time_dec[0] = time_q[0] - 4'd1;
        end else if (time_q[1] != '0) begin
            time_dec[1] = time_q[1] - 4'd1;
            time_dec[0] = 4'd9;
        end else begin
            time_dec[1] = 4'd5;
            time_dec[0] = 4'd9;
            borrow      = 1'b1;
            for (int i = 2; i < DIGITS; i++) begin
                if (borrow) begin
                    if (time_q[i] != '0) begin
                        time_dec[i] = time_q[i] - 4'd1;
                        borrow      = 1'b0;
                    end else begin
                        time_dec[i] = 4'd9;
                    end
                end
            end
        end
    end

`ifdef MICRO_ONDAS_QUICK_START_EN
    logic [DIGITS-1:0][BCD_W-1:0]   time_add;
    logic [BCD_W:0]                 tens_sum;
    logic                           add_carry, add_ok;

    // +30 s: tens plus three, wrapping at six with a decimal minute carry.
    // A carry out of the top digit cancels the add.
    always_comb begin
        time_add  = time_q;
        add_carry = 1'b0;
        tens_sum  = 5'(time_q[1]) + 5'(QUICK_SECS_TENS);
        if (tens_sum >= 5'd6) begin
            time_add[1] = 4'(tens_sum - 5'd6);
            add_carry   = 1'b1;
            for (int i = 2; i < DIGITS; i++) begin
                if (add_carry) begin
                    if (time_q[i] >= 4'd9) begin
                        time_add[i] = '0;
                    end else begin
                        time_add[i] = time_q[i] + 4'd1;
                        add_carry   = 1'b0;
                    end
                end
            end
        end else begin
            time_add[1] = 4'(tens_sum);
        end
        add_ok = ~add_carry;
    end
`endif

    // Next-state and register-update logic; events in priority order
    // door open > stop > start > power_key > keypad.
    always_comb begin
        state_d      = state_q;
        time_d       = time_q;
        power_d      = power_q;
        phase_d      = phase_q;
        presc_d      = presc_q;
        done_d       = 1'b0;
        key_prev_d   = keypad;
        pwr_prev_d   = power_key;
        start_prev_d = ~startn;
        stop_prev_d  = ~stopn;
        tick         = (presc_q == PRE_LAST);
        time_zero    = (time_q == '0);

        unique case (state_q)
            ST_IDLE: begin
                if (stop_press) begin
                    time_d  = '0;
                    power_d = DEFAULT_POWER;
                end else if (start_press) begin
                    if (door_closed && !time_zero) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                        phase_d = '0;
                    end
`ifdef MICRO_ONDAS_QUICK_START_EN
                    else if (door_closed) begin
                        time_d    = '0;
                        time_d[1] = QUICK_SECS_TENS;
                        state_d   = ST_RUN;
                        presc_d   = '0;
                        phase_d   = '0;
                    end
`endif
                end else if (pwr_press) begin
                    state_d = ST_PWRSEL;
                end else if (key_press) begin
                    time_d = {time_q[DIGITS-2:0], key_val};
                end
            end

            ST_PWRSEL: begin
                if (stop_press) begin
                    state_d = ST_IDLE;
                end else if (key_press) begin
                    power_d = (key_val == '0) ? DEFAULT_POWER : key_val;
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (!door_closed || stop_press) begin
                    // Pausing edge holds time, phase and prescaler.
                    state_d = ST_PAUSE;
                end else begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) phase_d = (phase_q == PHASE_MAX) ? '0 : phase_q + 4'd1;
`ifdef MICRO_ONDAS_QUICK_START_EN
                    if (start_press) begin
                        if (add_ok) time_d = time_add;
                    end else
`endif
                    if (tick) begin
                        time_d = time_dec;
                        if (time_dec == '0) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                            power_d = DEFAULT_POWER;
                        end
                    end
                end
            end

            ST_PAUSE: begin
                if (stop_press) begin
                    time_d  = '0;
                    power_d = DEFAULT_POWER;
                    state_d = ST_IDLE;
                end else if (start_press && door_closed) begin
                    state_d = ST_RUN;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs decode straight from the state register.
    always_comb begin
        running = (state_q == ST_RUN);
        paused  = (state_q == ST_PAUSE);
        done    = done_q;
        mag_on  = running & door_closed & (phase_q < power_q);
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seg7_dec u_dec (
            .bcd   (time_q[g]),
            .seg_c (segs[SEG_W*g +: SEG_W])
        );
    end

endmodule

// File: tb/tb_micro_ondas_pwr.sv
// Self-checking bench for micro_ondas_pwr (CLK_DIV=4, DIGITS=4).
module tb_micro_ondas_pwr;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned DIGITS  = 4;

    logic        clock = 1'b0;
    logic        clearn = 1'b0;
    logic [9:0]  keypad = '0;
    logic        power_key = 1'b0;
    logic        startn = 1'b1;
    logic        stopn = 1'b1;
    logic        door_closed = 1'b1;
    logic [27:0] segs;
    logic        mag_on, running, paused, done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_t;

    micro_ondas_pwr #(.CLK_DIV(CLK_DIV), .DIGITS(DIGITS)) dut (
        .clock       (clock),
        .clearn      (clearn),
        .keypad      (keypad),
        .power_key   (power_key),
        .startn      (startn),
        .stopn       (stopn),
        .door_closed (door_closed),
        .segs        (segs),
        .mag_on      (mag_on),
        .running     (running),
        .paused      (paused),
        .done        (done)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Reference 7-segment model (gfedcba).
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: seg_of = 7'h3F;  4'd1: seg_of = 7'h06;
            4'd2: seg_of = 7'h5B;  4'd3: seg_of = 7'h4F;
            4'd4: seg_of = 7'h66;  4'd5: seg_of = 7'h6D;
            4'd6: seg_of = 7'h7D;  4'd7: seg_of = 7'h07;
            4'd8: seg_of = 7'h7F;  4'd9: seg_of = 7'h6F;
            default: seg_of = 7'h00;
        endcase
    endfunction

    function automatic logic [27:0] disp(input logic [15:0] bcd);
        logic [27:0] r;
        for (int i = 0; i < 4; i++) r[7*i +: 7] = seg_of(bcd[4*i +: 4]);
        return r;
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic press_key(input int k);
        keypad = 10'(1 << k);
        cyc();
        keypad = '0;
        cyc();
    endtask

    task automatic press_power();
        power_key = 1'b1;
        cyc();
        power_key = 1'b0;
        cyc();
    endtask

    task automatic press_stop();
        stopn = 1'b0;
        cyc();
        stopn = 1'b1;
        cyc();
    endtask

    // Returns just after the edge that samples the press; release is left pending.
    task automatic press_start();
        startn = 1'b0;
        cyc();
        startn = 1'b1;
    endtask

    task automatic test_reset();
        clearn = 1'b0;
        repeat (2) cyc();
        n_checks++; if (segs !== disp(16'h0000)) begin n_fail++; $display("FAIL reset_segs: got %h want %h", segs, disp(16'h0000)); end
        n_checks++; if (mag_on !== 1'b0) begin n_fail++; $display("FAIL reset_mag_on: got %b want 0", mag_on); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", running); end
        n_checks++; if (paused !== 1'b0) begin n_fail++; $display("FAIL reset_paused: got %b want 0", paused); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        clearn = 1'b1;
        cyc();
    endtask

    task automatic test_entry();
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h2345);
        exp_q.push_back(16'h2345);
        exp_q.push_back(16'h0000);
        press_key(1); press_key(2); press_key(3); press_key(4);
        exp_t = exp_q.pop_front();
        n_checks++; if (segs !== disp(exp_t)) begin n_fail++; $display("FAIL entry_four: got %h want %h", segs, disp(exp_t)); end
        press_key(5);
        exp_t = exp_q.pop_front();
        n_checks++; if (segs !== disp(exp_t)) begin n_fail++; $display("FAIL entry_shift: got %h want %h", segs, disp(exp_t)); end
        keypad = 10'h003;
        cyc();
        keypad = '0;
        cyc();
        exp_t = exp_q.pop_front();
        n_checks++; if (segs !== disp(exp_t)) begin n_fail++; $display("FAIL entry_not_onehot: got %h want %h", segs, disp(exp_t)); end
        press_stop();
        exp_t = exp_q.pop_front();
        n_checks++; if (segs !== disp(exp_t)) begin n_fail++; $display("FAIL idle_stop_clear: got %h want %h", segs, disp(exp_t)); end
    endtask

    task automatic test_countdown();
        press_key(6); press_key(1);
        exp_q.push_back(16'h0060);
        exp_q.push_back(16'h0059);
        press_start();
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL cd_running: got %b want 1", running); end
        for (int t = 0; t < 2; t++) begin
            repeat (CLK_DIV) cyc();
            exp_t = exp_q.pop_front();
            n_checks++; if (segs !== disp(exp_t)) begin n_fail++; $display("FAIL cd_tick_%0d: got %h want %h", t, segs, disp(exp_t)); end
        end
        press_stop(); press_stop();
        press_key(1); press_key(0); press_key(0);
        exp_q.push_back(16'h0059);
        press_start();
        repeat (CLK_DIV) cyc();
        exp_t = exp_q.pop_front();
        n_checks++; if (segs !== disp(exp_t)) begin n_fail++; $display("FAIL cd_minute_borrow: got %h want %h", segs, disp(exp_t)); end
        press_stop(); press_stop();
        press_key(1);
        exp_q.push_back(16'h0000);
        press_start();
        repeat (CLK_DIV - 1) cyc();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL cd_done_early: got %b want 0", done); end
        cyc();
        exp_t = exp_q.pop_front();
        n_checks++; if (segs !== disp(exp_t)) begin n_fail++; $display("FAIL cd_zero: got %h want %h", segs, disp(exp_t)); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL cd_done_pulse: got %b want 1", done); end
        n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL cd_done_running: got %b want 0", running); end
        cyc();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL cd_done_width: got %b want 0", done); end
    endtask

    task automatic test_power();
        press_power(); press_key(3);
        press_key(2); press_key(0);
        exp_q.push_back(16'h0010);
        press_start();
        for (int t = 0; t < 10; t++) begin
            for (int c = 0; c < CLK_DIV; c++) begin
                n_checks++;
                if (mag_on !== (t < 3)) begin n_fail++; $display("FAIL pwr3_duty t%0d c%0d: got %b want %b", t, c, mag_on, (t < 3)); end
                cyc();
            end
        end
        exp_t = exp_q.pop_front();
        n_checks++; if (segs !== disp(exp_t)) begin n_fail++; $display("FAIL pwr3_time: got %h want %h", segs, disp(exp_t)); end
        press_power();
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL pwr_key_in_run: got running %b want 1", running); end
        press_stop(); press_stop();
        press_power(); press_key(3);
        press_power(); press_key(0);
        press_key(5);
        press_start();
        for (int c = 0; c < 4 * CLK_DIV; c++) begin
            n_checks++;
            if (mag_on !== 1'b1) begin n_fail++; $display("FAIL pwr10_on c%0d: got %b want 1", c, mag_on); end
            cyc();
        end
        press_stop(); press_stop();
    endtask

    task automatic test_door();
        press_key(3); press_key(0);
        exp_q.push_back(16'h0029);
        exp_q.push_back(16'h0029);
        exp_q.push_back(16'h0028);
        exp_q.push_back(16'h0000);
        press_start();
        repeat (CLK_DIV) cyc();
        exp_t = exp_q.pop_front();
        n_checks++; if (segs !== disp(exp_t)) begin n_fail++; $display("FAIL door_pre_time: got %h want %h", segs, disp(exp_t)); end
        n_checks++; if (mag_on !== 1'b1) begin n_fail++; $display("FAIL door_pre_mag: got %b want 1", mag_on); end
        door_closed = 1'b0;
        #1;
        n_checks++; if (mag_on !== 1'b0) begin n_fail++; $display("FAIL door_mag_same_cycle: got %b want 0", mag_on); end
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL door_before_edge: got running %b want 1", running); end
        cyc();
        n_checks++; if (paused !== 1'b1) begin n_fail++; $display("FAIL door_pause: got %b want 1", paused); end
        repeat (10) cyc();
        exp_t = exp_q.pop_front();
        n_checks++; if (segs !== disp(exp_t)) begin n_fail++; $display("FAIL door_frozen: got %h want %h", segs, disp(exp_t)); end
        door_closed = 1'b1;
        press_start();
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL door_resume: got running %b want 1", running); end
        repeat (CLK_DIV) cyc();
        exp_t = exp_q.pop_front();
        n_checks++; if (segs !== disp(exp_t)) begin n_fail++; $display("FAIL door_resume_tick: got %h want %h", segs, disp(exp_t)); end
        press_stop();
        n_checks++; if (paused !== 1'b1) begin n_fail++; $display("FAIL stop_pause: got %b want 1", paused); end
        press_stop();
        exp_t = exp_q.pop_front();
        n_checks++; if (segs !== disp(exp_t)) begin n_fail++; $display("FAIL pause_stop_clear: got %h want %h", segs, disp(exp_t)); end
        n_checks++; if (paused !== 1'b0 || running !== 1'b0) begin n_fail++; $display("FAIL pause_stop_idle: got paused %b running %b want 0 0", paused, running); end
    endtask

    task automatic test_priority_reset();
        press_key(9);
        press_start();
        cyc();
        stopn = 1'b0; startn = 1'b0;
        cyc();
        n_checks++; if (paused !== 1'b1 || running !== 1'b0) begin n_fail++; $display("FAIL stop_beats_start: got paused %b running %b want 1 0", paused, running); end
        stopn = 1'b1; startn = 1'b1;
        cyc();
        press_start();
        n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL prio_resume: got %b want 1", running); end
        cyc();
        clearn = 1'b0;
        cyc();
        n_checks++; if (segs !== disp(16'h0000)) begin n_fail++; $display("FAIL midrun_reset_segs: got %h want %h", segs, disp(16'h0000)); end
        n_checks++; if ({mag_on, running, paused, done} !== 4'b0000) begin n_fail++; $display("FAIL midrun_reset_flags: got %b want 0000", {mag_on, running, paused, done}); end
        clearn = 1'b1;
        cyc();
    endtask

    task automatic test_back_to_back_start();
        press_start();
`ifdef MICRO_ONDAS_QUICK_START_EN
        n_checks++; if (segs !== disp(16'h0030) || running !== 1'b1) begin n_fail++; $display("FAIL quick_load: got %h run %b want %h run 1", segs, running, disp(16'h0030)); end
        cyc();
        startn = 1'b0;
        cyc();
        startn = 1'b1;
        n_checks++; if (segs !== disp(16'h0100)) begin n_fail++; $display("FAIL quick_add: got %h want %h", segs, disp(16'h0100)); end
`else
        n_checks++; if (segs !== disp(16'h0000) || running !== 1'b0) begin n_fail++; $display("FAIL zero_start_ignored: got %h run %b want %h run 0", segs, running, disp(16'h0000)); end
        cyc();
        press_key(7);
        press_start();
        cyc();
        startn = 1'b0;
        cyc();
        startn = 1'b1;
        n_checks++; if (segs !== disp(16'h0007) || running !== 1'b1) begin n_fail++; $display("FAIL run_start_ignored: got %h run %b want %h run 1", segs, running, disp(16'h0007)); end
`endif
        clearn = 1'b0;
        cyc();
        clearn = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_entry();
        test_countdown();
        test_power();
        test_door();
        test_priority_reset();
        test_back_to_back_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
